// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between the ALU (source 0)
// and the load/store unit (source 1). The winning write is registered so the
// register file sees flop-driven write controls one cycle after acceptance.
// Optional feature macro: RF_WB_RR_EN. When it is defined, ties use
// round-robin arbitration. When it is undefined, source 0 always wins a tie
// and last_grant_o is tied to 0.
module rf_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              stall_i,
   input  logic              src0_valid_i,
   input  logic [ADDR_W-1:0] src0_addr_i,
   input  logic [DATA_W-1:0] src0_data_i,
   output logic              src0_ready_o,
   input  logic              src1_valid_i,
   input  logic [ADDR_W-1:0] src1_addr_i,
   input  logic [DATA_W-1:0] src1_data_i,
   output logic              src1_ready_o,
   output logic              rf_we_o,
   output logic [ADDR_W-1:0] rf_addr_o,
   output logic [DATA_W-1:0] rf_data_o,
   output logic              last_grant_o
);

   logic              w_grant0;
   logic              w_grant1;
   logic              w_transfer;
   logic              w_winIdx;
   logic [ADDR_W-1:0] w_winAddr;
   logic [DATA_W-1:0] w_winData;
   logic              w_lastGrant;

   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;

`ifdef RF_WB_RR_EN
   logic              r_lastGrant;

   // Round-robin grant: on a tie, the source that did not win last time is served
   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (rst_ni && !stall_i) begin
         if (src0_valid_i && src1_valid_i) begin
            w_grant0 = r_lastGrant;
            w_grant1 = ~r_lastGrant;
         end else begin
            w_grant0 = src0_valid_i;
            w_grant1 = src1_valid_i;
         end
      end
   end

   // Remember which source won the most recent transfer; reset favours source 0
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_lastGrant <= 1'b1;
      end else if (w_transfer) begin
         r_lastGrant <= w_winIdx;
      end
   end

   assign w_lastGrant = r_lastGrant;
`else
   // Fixed-priority grant: source 0 always beats source 1
   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (rst_ni && !stall_i) begin
         w_grant0 = src0_valid_i;
         w_grant1 = src1_valid_i & ~src0_valid_i;
      end
   end

   assign w_lastGrant = 1'b0;
`endif

   assign w_transfer = w_grant0 | w_grant1;
   assign w_winIdx   = w_grant1;
   assign w_winAddr  = w_grant1 ? src1_addr_i : src0_addr_i;
   assign w_winData  = w_grant1 ? src1_data_i : src0_data_i;

   // Output stage: capture the winner; a write to x0 is accepted but gated off
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_we   <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else begin
         r_we <= w_transfer && (w_winAddr != '0);
         if (w_transfer) begin
            r_addr <= w_winAddr;
            r_data <= w_winData;
         end
      end
   end

   assign src0_ready_o = w_grant0;
   assign src1_ready_o = w_grant1;
   assign rf_we_o      = r_we;
   assign rf_addr_o    = r_addr;
   assign rf_data_o    = r_data;
   assign last_grant_o = w_lastGrant;

endmodule
